fir_coeff_bank_ctrl: RTL and testbench
======================================

# fir_coeff_bank_ctrl

Double-buffered coefficient controller for the n-tap FIR. It holds two coefficient banks of LENGTH entries. A host writes new taps into the shadow bank while the filter keeps running on the active bank. On a commit request the banks swap and the controller streams the new active bank into the FIR's serial coefficient-load port under a valid/ready handshake. It replaces the test-only fixed-table coefficient source in the pulse-compression datapath.

## Interface
Parameters:
- LENGTH, 20, number of FIR taps per bank; must satisfy 2 ≤ LENGTH ≤ 2^ADDR_WIDTH.
- DATA_WIDTH, 18, signed coefficient width.
- ADDR_WIDTH, 10, width of host address and internal tap counter.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- resetN  in  1  reset, synchronous, active-low.
- hostWrEn  in  1  host write strobe, one word per cycle.
- hostWrAddr  in  ADDR_WIDTH  tap index in the shadow bank.
- hostWrData  in  DATA_WIDTH (signed)  coefficient value.
- hostWrErr  out  1  one-cycle pulse when a write is rejected.
- commitReq  in  1  request to swap banks and reload the FIR (level sampled each cycle).
- commitAck  out  1  one-cycle pulse on the cycle the swap takes effect.
- activeBank  out  1  index of the bank currently driving the FIR.
- coeffOut  out  DATA_WIDTH (signed)  coefficient to the FIR.
- coeffValid  out  1  coeffOut holds a valid tap.
- coeffReady  in  1  FIR accepts coeffOut this cycle.
- coeffSetFlag  out  1  high while the FIR holds a complete, current tap set.

## Operation
- Storage: two arrays of LENGTH × DATA_WIDTH with registered reads. Reset does not clear them; contents are undefined until written.
- Host writes always target bank ~activeBank (the shadow bank).
  - If hostWrAddr ≥ LENGTH, the write is dropped and hostWrErr pulses on the next cycle.
- States:
  - IDLE: after reset, no tap set loaded.
  - LOAD: streaming the active bank.
  - DONE: coeffSetFlag = 1.
- Swap: taken when commitReq = 1 (or a commit is pending) and the state is IDLE or DONE. At that edge:
  - activeBank toggles;
  - commitAck = 1;
  - coeffSetFlag = 0;
  - tap index = 0;
  - state → LOAD.
- A write in the same cycle as the swap lands in the pre-swap shadow bank, which becomes active. That write is included in the load.
- LOAD handshake: a tap transfers on any cycle with coeffValid & coeffReady.
  - coeffOut and coeffValid stay stable while coeffValid & !coeffReady.
  - Taps are sent in index order 0..LENGTH-1, exactly once each.
- After the transfer of tap LENGTH-1: coeffValid = 0, coeffSetFlag = 1, state → DONE.
- commitReq during LOAD: latched into a single pending bit. Further requests while pending merge into it; there is no queue depth > 1.
  - A pending commit is serviced from DONE one cycle after DONE is entered, so coeffSetFlag is high for exactly one cycle.
- Host writes during LOAD go to the shadow bank and never disturb the stream.
- Reset mid-LOAD aborts the stream. Every output takes its reset value at that edge, the pending bit clears, and no partial set is flagged.

## Timing
- Reset values: hostWrErr = 0, commitAck = 0, activeBank = 0, coeffOut = 0, coeffValid = 0, coeffSetFlag = 0, state IDLE, pending = 0.
- Let commitReq be sampled at edge T.
  - After T: commitAck = 1 (one cycle), activeBank toggled, coeffSetFlag = 0.
  - After T+1: coeffValid = 1 and coeffOut = tap 0 (registered-read latency).
- With coeffReady held high, tap k is presented after edge T+1+k. After edge T+LENGTH+1: coeffValid = 0 and coeffSetFlag = 1. Total commit-to-flag latency is LENGTH+1 cycles.
- Each cycle of coeffReady = 0 while valid adds exactly one cycle to that latency.
- hostWrErr: one cycle after the offending write.
- The write-to-memory path has one cycle of latency. A shadow write at edge W is readable by a load whose swap occurs at edge ≥ W.
- coeffOut returns to 0 whenever coeffValid = 0.

## Test plan
- Reset then commit: write taps 0..19 = 100..119 to bank 1, pulse commitReq, hold coeffReady = 1 → commitAck after 1 edge, activeBank = 1, coeffOut sequence 100..119 on consecutive cycles, coeffSetFlag high 21 cycles after the commit edge.
- Backpressure: same load with coeffReady low on every other cycle → each tap held until accepted, no tap skipped or duplicated, flag delayed by exactly the number of stall cycles.
- Out-of-range write: write addr 20 data 5 → hostWrErr pulses once, shadow contents unchanged on the next load.
- Commit during LOAD: issue commitReq twice mid-stream after rewriting bank 0 with −1..−20 → first load completes, flag high one cycle, single second swap to bank 0 streams −1..−20, no third load.
- Swap-cycle write: write addr 0 = 777 in the same cycle as commitReq → the first streamed tap is 777.
- Reset mid-LOAD: drop resetN at tap 7 → next cycle all outputs 0, activeBank = 0, state IDLE; a later commit streams bank 1 from tap 0.

Source files
------------

// File: rtl/fir_coeff_bank_ctrl.sv
// Double-buffered FIR coefficient banks: host fills the shadow bank, a commit swaps banks and streams
// the new active bank to the FIR (first tap one cycle after the swap, each tap held until coeffReady).
module fir_coeff_bank_ctrl #(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         hostWrEn,
    input  logic        [ADDR_WIDTH-1:0] hostWrAddr,
    input  logic signed [DATA_WIDTH-1:0] hostWrData,
    output logic                         hostWrErr,
    input  logic                         commitReq,
    output logic                         commitAck,
    output logic                         activeBank,
    output logic signed [DATA_WIDTH-1:0] coeffOut,
    output logic                         coeffValid,
    input  logic                         coeffReady,
    output logic                         coeffSetFlag
);

    localparam int              IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [ADDR_WIDTH:0] LEN_C = (ADDR_WIDTH+1)'(LENGTH);
    localparam logic [ADDR_WIDTH:0] ONE_C = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic signed [DATA_WIDTH-1:0] r_bank0 [LENGTH];
    logic signed [DATA_WIDTH-1:0] r_bank1 [LENGTH];
    logic                        r_active_bank;
    logic                        r_pending;
    logic                        r_wr_err;
    logic                        r_commit_ack;
    logic                        r_coeff_vld;
    logic signed [DATA_WIDTH-1:0] r_coeff_dat;
    logic                        r_set_flag;
    logic [ADDR_WIDTH:0]         r_tap_idx;

    logic                        w_addr_ok;
    logic [IW-1:0]               w_wr_idx;
    logic [IW-1:0]               w_rd_idx;
    logic signed [DATA_WIDTH-1:0] w_rd_dat;
    logic                        w_xfer;
    logic                        w_swap;
    logic                        w_fetch;
    logic                        w_finish;

    assign w_addr_ok = ({1'b0, hostWrAddr} < LEN_C);
    assign w_wr_idx  = hostWrAddr[IW-1:0];
    assign w_rd_idx  = r_tap_idx[IW-1:0];
    assign w_rd_dat  = r_active_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

    // Storage is never reset; the write always targets the bank that is not active at this edge,
    // so a write coinciding with a swap lands in the bank about to be streamed.
    always_ff @(posedge clock) begin
        if (hostWrEn && w_addr_ok) begin
            if (r_active_bank) begin
                r_bank0[w_wr_idx] <= hostWrData;
            end else begin
                r_bank1[w_wr_idx] <= hostWrData;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_fetch     = 1'b0;
        w_finish    = 1'b0;
        w_xfer      = r_coeff_vld & coeffReady;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (commitReq || r_pending) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Fetch the next tap whenever the output register is empty or being drained.
                if ((!r_coeff_vld || w_xfer) && (r_tap_idx < LEN_C)) begin
                    w_fetch = 1'b1;
                end else if (w_xfer) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_active_bank <= 1'b0;
            r_pending     <= 1'b0;
            r_wr_err      <= 1'b0;
            r_commit_ack  <= 1'b0;
            r_coeff_vld   <= 1'b0;
            r_coeff_dat   <= '0;
            r_set_flag    <= 1'b0;
            r_tap_idx     <= '0;
        end else begin
            r_wr_err     <= hostWrEn && !w_addr_ok;
            r_commit_ack <= w_swap;
            if (w_swap) begin
                r_active_bank <= ~r_active_bank;
                r_pending     <= 1'b0;
                r_set_flag    <= 1'b0;
                r_tap_idx     <= '0;
                r_coeff_vld   <= 1'b0;
                r_coeff_dat   <= '0;
            end else begin
                if (r_state == S_LOAD && commitReq) begin
                    r_pending <= 1'b1;
                end
                if (w_fetch) begin
                    r_coeff_dat <= w_rd_dat;
                    r_coeff_vld <= 1'b1;
                    r_tap_idx   <= r_tap_idx + ONE_C;
                end else if (w_finish) begin
                    r_coeff_dat <= '0;
                    r_coeff_vld <= 1'b0;
                    r_set_flag  <= 1'b1;
                end
            end
        end
    end

    assign hostWrErr    = r_wr_err;
    assign commitAck    = r_commit_ack;
    assign activeBank   = r_active_bank;
    assign coeffOut     = r_coeff_dat;
    assign coeffValid   = r_coeff_vld;
    assign coeffSetFlag = r_set_flag;

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Directed bench for fir_coeff_bank_ctrl: a bank model feeds an expected-tap queue on each swap,
// and a monitor pops and compares every accepted tap.
module tb_fir_coeff_bank_ctrl;

    localparam int LENGTH = 20;
    localparam int DW     = 18;
    localparam int AW     = 10;

    logic                 clock = 1'b0;
    logic                 resetN;
    logic                 hostWrEn;
    logic        [AW-1:0] hostWrAddr;
    logic signed [DW-1:0] hostWrData;
    logic                 hostWrErr;
    logic                 commitReq;
    logic                 commitAck;
    logic                 activeBank;
    logic signed [DW-1:0] coeffOut;
    logic                 coeffValid;
    logic                 coeffReady;
    logic                 coeffSetFlag;

    fir_coeff_bank_ctrl #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .hostWrEn     (hostWrEn),
        .hostWrAddr   (hostWrAddr),
        .hostWrData   (hostWrData),
        .hostWrErr    (hostWrErr),
        .commitReq    (commitReq),
        .commitAck    (commitAck),
        .activeBank   (activeBank),
        .coeffOut     (coeffOut),
        .coeffValid   (coeffValid),
        .coeffReady   (coeffReady),
        .coeffSetFlag (coeffSetFlag)
    );

    always #5 clock = ~clock;

    int                   checks = 0;
    int                   errors = 0;
    int                   stalls = 0;
    logic signed [DW-1:0] q[$];
    logic signed [DW-1:0] m_bank [2][LENGTH];
    bit                   mact = 1'b0;
    bit                   held_vld = 1'b0;
    logic signed [DW-1:0] held_val = '0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accepted taps are compared against the queue; stalled taps must hold value until accepted.
    always @(negedge clock) begin
        if (!resetN) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                chk("hold_vld", coeffValid, 1);
                chk("hold_dat", coeffOut, held_val);
            end
            if (coeffValid) begin
                if (coeffReady) begin
                    held_vld = 1'b0;
                    if (q.size() == 0) chk("extra_tap", 1, 0);
                    else chk("tap", coeffOut, q.pop_front());
                end else begin
                    held_vld = 1'b1;
                    held_val = coeffOut;
                    stalls++;
                end
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    task automatic push_active();
        for (int i = 0; i < LENGTH; i++) q.push_back(m_bank[mact][i]);
        stalls = 0;
    endtask

    task automatic commit(input bit with_wr, input logic signed [DW-1:0] wdat);
        commitReq = 1'b1;
        if (with_wr) begin
            hostWrEn   = 1'b1;
            hostWrAddr = '0;
            hostWrData = wdat;
            m_bank[~mact][0] = wdat;
        end
        tick();
        commitReq = 1'b0;
        hostWrEn  = 1'b0;
        mact      = ~mact;
        push_active();
        chk("ack", commitAck, 1);
        chk("active", activeBank, mact);
        chk("flag_clr", coeffSetFlag, 0);
        chk("vld_at_swap", coeffValid, 0);
    endtask

    // Runs from the cycle after the swap edge until coeffSetFlag; optional stalls and mid-load traffic.
    task automatic run_load(input bit stall, input bit mid);
        int cnt = 0;
        while (1) begin
            int k = cnt + 1;
            coeffReady = stall ? (cnt % 2 == 1) : 1'b1;
            if (mid && k <= LENGTH) begin
                hostWrEn   = 1'b1;
                hostWrAddr = AW'(k - 1);
                hostWrData = DW'(-k);
                m_bank[~mact][k-1] = DW'(-k);
            end
            if (mid && (k == 5 || k == 9)) commitReq = 1'b1;
            tick();
            hostWrEn  = 1'b0;
            commitReq = 1'b0;
            cnt++;
            if (coeffSetFlag) break;
            if (cnt > 200) begin
                chk("flag_timeout", cnt, -1);
                break;
            end
        end
        coeffReady = 1'b1;
        chk("latency", cnt, LENGTH + 1 + stalls);
        chk("vld_done", coeffValid, 0);
        chk("out_done", coeffOut, 0);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; hostWrEn = 1'b0; hostWrAddr = '0; hostWrData = '0;
        commitReq = 1'b0; coeffReady = 1'b1;
        tick(); tick();
        chk("rst_err", hostWrErr, 0);
        chk("rst_ack", commitAck, 0);
        chk("rst_active", activeBank, 0);
        chk("rst_out", coeffOut, 0);
        chk("rst_vld", coeffValid, 0);
        chk("rst_flag", coeffSetFlag, 0);
        resetN = 1'b1;
        tick();

        // Bank 1 <= 100..119, commit with ready held high.
        for (int i = 0; i < LENGTH; i++) begin
            hostWrEn = 1'b1; hostWrAddr = AW'(i); hostWrData = DW'(100 + i);
            m_bank[1][i] = DW'(100 + i);
            tick();
        end
        hostWrEn = 1'b0;
        chk("inrange_err", hostWrErr, 0);
        chk("idle_vld", coeffValid, 0);
        commit(1'b0, '0);
        run_load(1'b0, 1'b0);

        // Bank 0 <= 200..219, then out-of-range writes, then a backpressured load.
        for (int i = 0; i < LENGTH; i++) begin
            hostWrEn = 1'b1; hostWrAddr = AW'(i); hostWrData = DW'(200 + i);
            m_bank[0][i] = DW'(200 + i);
            tick();
        end
        hostWrEn = 1'b1; hostWrAddr = AW'(20); hostWrData = DW'(5);
        tick();
        hostWrEn = 1'b0;
        chk("oor_err20", hostWrErr, 1);
        tick();
        chk("oor_err_once", hostWrErr, 0);
        hostWrEn = 1'b1; hostWrAddr = AW'(33); hostWrData = DW'(5);
        tick();
        hostWrEn = 1'b0;
        chk("oor_err33", hostWrErr, 1);
        commit(1'b0, '0);
        run_load(1'b1, 1'b0);

        // Commit to bank 1; during the load rewrite bank 0 with -1..-20 and request twice.
        commit(1'b0, '0);
        run_load(1'b0, 1'b1);
        tick();
        chk("pend_ack", commitAck, 1);
        chk("pend_active", activeBank, 0);
        chk("pend_flag_one_cycle", coeffSetFlag, 0);
        mact = 1'b0;
        push_active();
        run_load(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_third_ack", commitAck, 0);
            chk("no_third_vld", coeffValid, 0);
            chk("flag_hold", coeffSetFlag, 1);
        end

        // Swap-cycle write to addr 0, then reset at tap 7 with a commit pending.
        commit(1'b1, DW'(777));
        tick();
        chk("first_tap_vld", coeffValid, 1);
        chk("first_tap_777", coeffOut, 777);
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) commitReq = 1'b1;
            tick();
            commitReq = 1'b0;
        end
        chk("tap7", coeffOut, m_bank[1][7]);
        resetN = 1'b0;
        tick();
        q.delete();
        chk("mid_rst_active", activeBank, 0);
        chk("mid_rst_out", coeffOut, 0);
        chk("mid_rst_vld", coeffValid, 0);
        chk("mid_rst_flag", coeffSetFlag, 0);
        chk("mid_rst_ack", commitAck, 0);
        chk("mid_rst_err", hostWrErr, 0);
        resetN = 1'b1;
        mact   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_ack", commitAck, 0);
            chk("post_rst_vld", coeffValid, 0);
            chk("post_rst_flag", coeffSetFlag, 0);
        end
        commit(1'b0, '0);
        run_load(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
